feature_bank_ctrl: RTL and testbench

FEATURE_BANK_CTRL -- requirements
Module: feature_bank_ctrl

---
 rtl/feature_bank_pkg.sv | 47 ++++
 rtl/feature_bank_ctrl_sat_counter.sv | 41 ++++
 rtl/feature_bank_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_feature_bank_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/feature_bank_pkg.sv
// Shared definitions for the double-buffered feature bank controller:
// custom-instruction op codes, bank and FSM state encodings, STATUS word
// layout and the result returned when a blocking ACQUIRE times out.
package feature_bank_pkg;

  typedef enum logic [1:0] {
    OP_ACQUIRE   = 2'd0,
    OP_RELEASE   = 2'd1,
    OP_STATUS    = 2'd2,
    OP_CLEARDROP = 2'd3
  } ci_op_e;

  typedef enum logic [1:0] {
    BANK_FREE   = 2'd0,
    BANK_FILLED = 2'd1,
    BANK_HELD   = 2'd2
  } bank_state_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

  localparam int unsigned DROP_WIDTH            = 32'd16;
  localparam int unsigned STATUS_WRITE_BANK_BIT = 32'd0;
  localparam int unsigned STATUS_ANY_FILLED_BIT = 32'd1;
  localparam int unsigned STATUS_BANK_HELD_BIT  = 32'd2;
  localparam int unsigned STATUS_DROP_LSB       = 32'd16;

  localparam logic [31:0] TIMEOUT_RESULT = 32'hFFFF_FFFF;

  // Assemble the STATUS response word from its fields.
  function automatic logic [31:0] pack_status(input logic [15:0] drop,
                                              input logic        held,
                                              input logic        any_filled,
                                              input logic        write_bank);
    logic [31:0] s;
    s = 32'd0;
    s[STATUS_DROP_LSB +: 16]  = drop;
    s[STATUS_BANK_HELD_BIT]   = held;
    s[STATUS_ANY_FILLED_BIT]  = any_filled;
    s[STATUS_WRITE_BANK_BIT]  = write_bank;
    return s;
  endfunction

endpackage

// File: rtl/feature_bank_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Used for the dropped-frame count of feature_bank_ctrl.
module sat_counter #(
  parameter int unsigned WIDTH = 32'd16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear first, otherwise increment until the ceiling.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {WIDTH{1'b0}};
    end else if (inc_i && (count_q != CNT_MAX)) begin
      count_d = count_q + WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/feature_bank_ctrl.sv
// Two-bank feature buffer arbiter between a frame producer and a CPU that
// talks to it through a custom instruction (ACQUIRE / RELEASE / STATUS /
// CLEARDROP). A frame completion is applied before the CPU op of the same
// cycle. Build option FEATURE_BANK_TIMEOUT_EN bounds a blocking ACQUIRE to
// TIMEOUT_CYCLES wait cycles; without it the wait is unbounded.
module feature_bank_ctrl
  import feature_bank_pkg::*;
#(
  parameter logic [7:0]  CUSTOM_INSTRUCTION_ID = 8'd42,
  parameter int unsigned TIMEOUT_CYCLES        = 32'd1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frameDone,
  input  logic [31:0] frameFeatures,
  output logic        writeBank,
  output logic        readBank,
  output logic        bankHeld,
  input  logic        ciStart,
  input  logic        ciCke,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic [31:0] ciResult,
  output logic        ciDone
);

  fsm_state_e  fsm_q, fsm_d;
  bank_state_e bank_state_q [2];
  bank_state_e bank_state_d [2];
  logic [31:0] bank_count_q [2];
  logic [31:0] bank_count_d [2];
  logic        write_bank_q, write_bank_d;
  logic        read_bank_q, read_bank_d;
  logic        bank_held_q, bank_held_d;
  logic        ci_done_q, ci_done_d;
  logic [31:0] ci_result_q, ci_result_d;

  logic        accept_s;
  ci_op_e      op_s;
  logic        other_bank_s;
  logic        try_acquire_s;
  logic        timeout_hit_s;
  logic        drop_inc_s;
  logic        drop_clr_s;
  logic [15:0] drop_count_s;

  assign accept_s     = ciStart && ciCke && (ciN == CUSTOM_INSTRUCTION_ID) && (fsm_q == ST_IDLE);
  assign op_s         = ci_op_e'(ciValueA[1:0]);
  assign other_bank_s = ~write_bank_q;

`ifdef FEATURE_BANK_TIMEOUT_EN
  logic [31:0] wait_cnt_q;

  assign timeout_hit_s = (fsm_q == ST_WAIT) && (wait_cnt_q == (TIMEOUT_CYCLES - 32'd1));

  // Count consecutive cycles spent waiting for a filled bank.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= 32'd0;
    end else if (fsm_q == ST_WAIT) begin
      wait_cnt_q <= wait_cnt_q + 32'd1;
    end else begin
      wait_cnt_q <= 32'd0;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{ciValueB, ciValueA[31:2]};
`else
  assign timeout_hit_s = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{ciValueB, ciValueA[31:2], TIMEOUT_RESULT, 32'(TIMEOUT_CYCLES)};
`endif

  // Apply the frame completion, then the CPU op against the updated banks.
  always_comb begin
    fsm_d         = fsm_q;
    bank_state_d  = bank_state_q;
    bank_count_d  = bank_count_q;
    write_bank_d  = write_bank_q;
    read_bank_d   = read_bank_q;
    bank_held_d   = bank_held_q;
    ci_done_d     = 1'b0;
    ci_result_d   = 32'd0;
    drop_inc_s    = 1'b0;
    drop_clr_s    = 1'b0;
    try_acquire_s = 1'b0;

    // Producer side: the write bank is never FILLED/HELD, so only the
    // other bank decides what happens to the finished frame.
    if (frameDone) begin
      case (bank_state_q[other_bank_s])
        BANK_FREE: begin
          bank_state_d[write_bank_q] = BANK_FILLED;
          bank_count_d[write_bank_q] = frameFeatures;
          write_bank_d               = other_bank_s;
        end
        BANK_FILLED: begin
          // Keep the newest frame; the stale one is recycled as write bank.
          bank_state_d[write_bank_q] = BANK_FILLED;
          bank_count_d[write_bank_q] = frameFeatures;
          bank_state_d[other_bank_s] = BANK_FREE;
          write_bank_d               = other_bank_s;
          drop_inc_s                 = 1'b1;
        end
        BANK_HELD: begin
          drop_inc_s = 1'b1;
        end
        default: begin
          drop_inc_s = 1'b0;
        end
      endcase
    end else begin
      drop_inc_s = 1'b0;
    end

    // CPU side.
    case (fsm_q)
      ST_IDLE: begin
        if (accept_s) begin
          case (op_s)
            OP_ACQUIRE: begin
              if (bank_held_q) begin
                bank_state_d[read_bank_q] = BANK_FREE;
                bank_held_d               = 1'b0;
              end else begin
                bank_held_d = 1'b0;
              end
              try_acquire_s = 1'b1;
            end
            OP_RELEASE: begin
              if (bank_held_q) begin
                bank_state_d[read_bank_q] = BANK_FREE;
                bank_held_d               = 1'b0;
              end else begin
                bank_held_d = 1'b0;
              end
              ci_done_d = 1'b1;
              fsm_d     = ST_DONE;
            end
            OP_STATUS: begin
              ci_result_d = pack_status(drop_count_s, bank_held_d,
                                        (bank_state_d[0] == BANK_FILLED) ||
                                        (bank_state_d[1] == BANK_FILLED),
                                        write_bank_d);
              ci_done_d   = 1'b1;
              fsm_d       = ST_DONE;
            end
            OP_CLEARDROP: begin
              ci_result_d = {16'd0, drop_count_s};
              drop_clr_s  = 1'b1;
              ci_done_d   = 1'b1;
              fsm_d       = ST_DONE;
            end
            default: begin
              fsm_d = ST_IDLE;
            end
          endcase
        end else begin
          fsm_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        try_acquire_s = 1'b1;
      end
      ST_DONE: begin
        fsm_d = ST_IDLE;
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase

    // ACQUIRE resolution: only the non-write bank can hold a frame.
    if (try_acquire_s) begin
      if (bank_state_d[~write_bank_d] == BANK_FILLED) begin
        bank_state_d[~write_bank_d] = BANK_HELD;
        read_bank_d                 = ~write_bank_d;
        bank_held_d                 = 1'b1;
        ci_result_d                 = bank_count_d[~write_bank_d];
        ci_done_d                   = 1'b1;
        fsm_d                       = ST_DONE;
      end else if (timeout_hit_s) begin
        bank_held_d = 1'b0;
        ci_result_d = TIMEOUT_RESULT;
        ci_done_d   = 1'b1;
        fsm_d       = ST_DONE;
      end else begin
        fsm_d = ST_WAIT;
      end
    end else begin
      read_bank_d = read_bank_d;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm_q           <= ST_IDLE;
      bank_state_q[0] <= BANK_FREE;
      bank_state_q[1] <= BANK_FREE;
      bank_count_q[0] <= 32'd0;
      bank_count_q[1] <= 32'd0;
      write_bank_q    <= 1'b0;
      read_bank_q     <= 1'b0;
      bank_held_q     <= 1'b0;
      ci_done_q       <= 1'b0;
      ci_result_q     <= 32'd0;
    end else begin
      fsm_q        <= fsm_d;
      bank_state_q <= bank_state_d;
      bank_count_q <= bank_count_d;
      write_bank_q <= write_bank_d;
      read_bank_q  <= read_bank_d;
      bank_held_q  <= bank_held_d;
      ci_done_q    <= ci_done_d;
      ci_result_q  <= ci_result_d;
    end
  end

  sat_counter #(
    .WIDTH (DROP_WIDTH)
  ) u_drop_count (
    .clk_i   (clock),
    .rst_ni  (reset),
    .inc_i   (drop_inc_s),
    .clr_i   (drop_clr_s),
    .count_o (drop_count_s)
  );

  assign writeBank = write_bank_q;
  assign readBank  = read_bank_q;
  assign bankHeld  = bank_held_q;
  assign ciDone    = ci_done_q;
  assign ciResult  = ci_result_q;

endmodule

// File: tb/tb_feature_bank_ctrl.sv
// Scoreboard bench for feature_bank_ctrl: expected ciResult values are queued
// when an op is issued and popped whenever ciDone is seen.
module tb_feature_bank_ctrl;

  localparam logic [7:0] CI_ID   = 8'd42;
  localparam logic [1:0] OP_ACQ  = 2'd0;
  localparam logic [1:0] OP_REL  = 2'd1;
  localparam logic [1:0] OP_STAT = 2'd2;
  localparam logic [1:0] OP_CLR  = 2'd3;

  logic        clock;
  logic        reset;
  logic        frameDone;
  logic [31:0] frameFeatures;
  logic        writeBank;
  logic        readBank;
  logic        bankHeld;
  logic        ciStart;
  logic        ciCke;
  logic [7:0]  ciN;
  logic [31:0] ciValueA;
  logic [31:0] ciValueB;
  logic [31:0] ciResult;
  logic        ciDone;

  int          compared;
  int          mismatched;
  int          done_count;
  logic [31:0] sb_q [$];

  feature_bank_ctrl #(
    .CUSTOM_INSTRUCTION_ID (8'd42),
    .TIMEOUT_CYCLES        (32'd100)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .frameDone     (frameDone),
    .frameFeatures (frameFeatures),
    .writeBank     (writeBank),
    .readBank      (readBank),
    .bankHeld      (bankHeld),
    .ciStart       (ciStart),
    .ciCke         (ciCke),
    .ciN           (ciN),
    .ciValueA      (ciValueA),
    .ciValueB      (ciValueB),
    .ciResult      (ciResult),
    .ciDone        (ciDone)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t, limit 2000000", $time);
    $fatal(1);
  end

  // One clock: advance past the rising edge, sample at the falling edge and
  // retire any response against the scoreboard.
  task automatic clock_cycle();
    logic [31:0] exp;
    @(posedge clock);
    @(negedge clock);
    compared++;
    if (ciDone === 1'b1) begin
      done_count++;
      if (sb_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_done: ciResult=%h with no request outstanding", ciResult);
      end else begin
        exp = sb_q.pop_front();
        if (ciResult !== exp) begin
          mismatched++;
          $display("FAIL ci_result: got %h, expected %h", ciResult, exp);
        end
      end
    end else if (ciResult !== 32'd0) begin
      mismatched++;
      $display("FAIL idle_result: ciResult=%h while ciDone=0, expected 00000000", ciResult);
    end
  endtask

  task automatic set_op(input logic [1:0] op, input logic [7:0] id);
    ciStart  = 1'b1;
    ciCke    = 1'b1;
    ciN      = id;
    ciValueA = {30'($urandom), op};
    ciValueB = $urandom;
  endtask

  task automatic clear_op();
    ciStart  = 1'b0;
    ciCke    = 1'b0;
    ciN      = 8'd0;
    ciValueA = 32'd0;
    ciValueB = 32'd0;
  endtask

  task automatic frame(input logic [31:0] n);
    frameDone     = 1'b1;
    frameFeatures = n;
    clock_cycle();
    frameDone     = 1'b0;
    frameFeatures = $urandom;
  endtask

  // Non-blocking op (or ACQUIRE with a frame ready): response the next cycle.
  task automatic issue_op(input logic [1:0] op, input logic [31:0] exp, input string name);
    sb_q.push_back(exp);
    set_op(op, CI_ID);
    clock_cycle();
    clear_op();
    compared++;
    if (ciDone !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_latency: ciDone=%b one cycle after issue, expected 1", name, ciDone);
    end
    clock_cycle();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    clear_op();
    frameDone     = 1'b0;
    frameFeatures = 32'd0;
    clock_cycle();
    clock_cycle();
    reset = 1'b1;
    clock_cycle();
  endtask

  task automatic test_reset();
    apply_reset();
    compared += 5;
    if (writeBank !== 1'b0) begin mismatched++; $display("FAIL rst_writeBank: got %b, expected 0", writeBank); end
    if (readBank  !== 1'b0) begin mismatched++; $display("FAIL rst_readBank: got %b, expected 0", readBank); end
    if (bankHeld  !== 1'b0) begin mismatched++; $display("FAIL rst_bankHeld: got %b, expected 0", bankHeld); end
    if (ciDone    !== 1'b0) begin mismatched++; $display("FAIL rst_ciDone: got %b, expected 0", ciDone); end
    if (ciResult  !== 32'd0) begin mismatched++; $display("FAIL rst_ciResult: got %h, expected 0", ciResult); end
    issue_op(OP_STAT, 32'h0000_0000, "rst_status");
  endtask

  task automatic test_acquire_wait();
    apply_reset();
    sb_q.push_back(32'd12);
    set_op(OP_ACQ, CI_ID);
    clock_cycle();
    clear_op();
    compared++;
    if (ciDone !== 1'b0) begin mismatched++; $display("FAIL acq_wait_early: ciDone=%b, expected 0", ciDone); end
    clock_cycle();
    frame(32'd12);
    compared += 4;
    if (ciDone    !== 1'b1) begin mismatched++; $display("FAIL acq_wait_done: got %b, expected 1", ciDone); end
    if (readBank  !== 1'b0) begin mismatched++; $display("FAIL acq_wait_readBank: got %b, expected 0", readBank); end
    if (writeBank !== 1'b1) begin mismatched++; $display("FAIL acq_wait_writeBank: got %b, expected 1", writeBank); end
    if (bankHeld  !== 1'b1) begin mismatched++; $display("FAIL acq_wait_bankHeld: got %b, expected 1", bankHeld); end
    clock_cycle();
    issue_op(OP_REL, 32'd0, "release");
    compared++;
    if (bankHeld !== 1'b0) begin mismatched++; $display("FAIL release_bankHeld: got %b, expected 0", bankHeld); end
    issue_op(OP_STAT, 32'h0000_0001, "status_after_release");
  endtask

  task automatic test_latest_frame();
    apply_reset();
    frame(32'd12);
    frame(32'd22);
    issue_op(OP_STAT, 32'h0001_0002, "status_latest");
    issue_op(OP_ACQ, 32'd22, "acquire_latest");
    compared += 3;
    if (readBank  !== 1'b1) begin mismatched++; $display("FAIL latest_readBank: got %b, expected 1", readBank); end
    if (bankHeld  !== 1'b1) begin mismatched++; $display("FAIL latest_bankHeld: got %b, expected 1", bankHeld); end
    if (writeBank !== 1'b0) begin mismatched++; $display("FAIL latest_writeBank: got %b, expected 0", writeBank); end
  endtask

  // Continues from test_latest_frame: bank 1 held, write bank 0, one drop.
  task automatic test_held_drop();
    frame(32'd32);
    compared++;
    if (writeBank !== 1'b0) begin mismatched++; $display("FAIL held_drop1_writeBank: got %b, expected 0", writeBank); end
    frame(32'd40);
    compared++;
    if (writeBank !== 1'b0) begin mismatched++; $display("FAIL held_drop2_writeBank: got %b, expected 0", writeBank); end
    issue_op(OP_STAT, 32'h0003_0004, "status_held");
    issue_op(OP_CLR, 32'd3, "cleardrop");
    issue_op(OP_STAT, 32'h0000_0004, "status_cleared");
    issue_op(OP_REL, 32'd0, "release_held");
    compared++;
    if (bankHeld !== 1'b0) begin mismatched++; $display("FAIL held_release: got %b, expected 0", bankHeld); end
    issue_op(OP_REL, 32'd0, "release_noop");
    issue_op(OP_STAT, 32'h0000_0000, "status_all_free");
  endtask

  task automatic test_same_cycle();
    apply_reset();
    frame(32'd5);
    sb_q.push_back(32'd7);
    set_op(OP_ACQ, CI_ID);
    frameDone     = 1'b1;
    frameFeatures = 32'd7;
    clock_cycle();
    clear_op();
    frameDone = 1'b0;
    compared += 4;
    if (ciDone    !== 1'b1) begin mismatched++; $display("FAIL same_cycle_done: got %b, expected 1", ciDone); end
    if (readBank  !== 1'b1) begin mismatched++; $display("FAIL same_cycle_readBank: got %b, expected 1", readBank); end
    if (writeBank !== 1'b0) begin mismatched++; $display("FAIL same_cycle_writeBank: got %b, expected 0", writeBank); end
    if (bankHeld  !== 1'b1) begin mismatched++; $display("FAIL same_cycle_bankHeld: got %b, expected 1", bankHeld); end
    clock_cycle();
    issue_op(OP_STAT, 32'h0001_0004, "same_cycle_status");
    // Re-acquire while holding: the held bank is released and the CPU waits.
    sb_q.push_back(32'd9);
    set_op(OP_ACQ, CI_ID);
    clock_cycle();
    clear_op();
    compared += 2;
    if (bankHeld !== 1'b0) begin mismatched++; $display("FAIL reacquire_release: got %b, expected 0", bankHeld); end
    if (ciDone   !== 1'b0) begin mismatched++; $display("FAIL reacquire_early: got %b, expected 0", ciDone); end
    frame(32'd9);
    compared += 4;
    if (ciDone    !== 1'b1) begin mismatched++; $display("FAIL reacquire_done: got %b, expected 1", ciDone); end
    if (readBank  !== 1'b0) begin mismatched++; $display("FAIL reacquire_readBank: got %b, expected 0", readBank); end
    if (writeBank !== 1'b1) begin mismatched++; $display("FAIL reacquire_writeBank: got %b, expected 1", writeBank); end
    if (bankHeld  !== 1'b1) begin mismatched++; $display("FAIL reacquire_bankHeld: got %b, expected 1", bankHeld); end
    clock_cycle();
    // Dropped frame in the same cycle as CLEARDROP: the increment is lost.
    sb_q.push_back(32'd1);
    set_op(OP_CLR, CI_ID);
    frameDone     = 1'b1;
    frameFeatures = 32'd77;
    clock_cycle();
    clear_op();
    frameDone = 1'b0;
    clock_cycle();
    issue_op(OP_STAT, 32'h0000_0005, "clear_race_status");
  endtask

  task automatic test_timeout();
    int first;
    apply_reset();
`ifdef FEATURE_BANK_TIMEOUT_EN
    sb_q.push_back(32'hFFFF_FFFF);
`endif
    set_op(OP_ACQ, CI_ID);
    clock_cycle();
    clear_op();
    first = 0;
    for (int i = 1; i <= 1000; i++) begin
      if ((ciDone === 1'b1) && (first == 0)) first = i;
      if (first != 0) break;
      clock_cycle();
    end
    compared++;
`ifdef FEATURE_BANK_TIMEOUT_EN
    if (first != 101) begin mismatched++; $display("FAIL timeout_cycle: ciDone at cycle %0d, expected 101", first); end
    compared++;
    if (bankHeld !== 1'b0) begin mismatched++; $display("FAIL timeout_bankHeld: got %b, expected 0", bankHeld); end
    clock_cycle();
`else
    if (first != 0) begin mismatched++; $display("FAIL wait_forever: ciDone at cycle %0d, expected none in 1000", first); end
`endif
  endtask

  task automatic test_reset_mid_wait();
    int d0;
    apply_reset();
    frame(32'd5);
    frame(32'd6);
    issue_op(OP_ACQ, 32'd6, "pre_wait_acquire");
    set_op(OP_ACQ, CI_ID);
    clock_cycle();
    clear_op();
    repeat (3) clock_cycle();
    compared++;
    if (readBank !== 1'b1) begin mismatched++; $display("FAIL pre_reset_readBank: got %b, expected 1", readBank); end
    reset = 1'b0;
    #1;
    compared += 5;
    if (writeBank !== 1'b0) begin mismatched++; $display("FAIL midwait_writeBank: got %b, expected 0", writeBank); end
    if (readBank  !== 1'b0) begin mismatched++; $display("FAIL midwait_readBank: got %b, expected 0", readBank); end
    if (bankHeld  !== 1'b0) begin mismatched++; $display("FAIL midwait_bankHeld: got %b, expected 0", bankHeld); end
    if (ciDone    !== 1'b0) begin mismatched++; $display("FAIL midwait_ciDone: got %b, expected 0", ciDone); end
    if (ciResult  !== 32'd0) begin mismatched++; $display("FAIL midwait_ciResult: got %h, expected 0", ciResult); end
    clock_cycle();
    clock_cycle();
    reset = 1'b1;
    d0 = done_count;
    repeat (20) clock_cycle();
    compared++;
    if (done_count != d0) begin mismatched++; $display("FAIL midwait_no_done: %0d responses after reset, expected 0", done_count - d0); end
    issue_op(OP_STAT, 32'h0000_0000, "post_reset_status");
  endtask

  task automatic test_ignored_requests();
    int d0;
    d0 = done_count;
    set_op(OP_STAT, 8'd41);
    clock_cycle();
    clear_op();
    set_op(OP_STAT, CI_ID);
    ciCke = 1'b0;
    clock_cycle();
    clear_op();
    set_op(OP_STAT, CI_ID);
    ciStart = 1'b0;
    clock_cycle();
    clear_op();
    repeat (5) clock_cycle();
    compared++;
    if (done_count != d0) begin mismatched++; $display("FAIL ignored_requests: %0d responses, expected 0", done_count - d0); end
    issue_op(OP_STAT, 32'h0000_0000, "alive_status");
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    done_count    = 0;
    reset         = 1'b0;
    frameDone     = 1'b0;
    frameFeatures = 32'd0;
    clear_op();

    test_reset();
    test_acquire_wait();
    test_latest_frame();
    test_held_drop();
    test_same_cycle();
    test_timeout();
    test_reset_mid_wait();
    test_ignored_requests();

    compared++;
    if (sb_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
